// File: rtl/cpu_mu0_waitreq.sv
// MU0 core: waitrequest-stalled memory bus, registered OUT port; MU0_ILLEGAL_TRAP_EN makes illegal opcodes halt with fault.
// Latency: 3 cycles per instruction (4 for LDA/ADD/SUB) plus one cycle per waitrequest cycle.
// Backpressure: a pending read/write holds address, request and writedata until waitrequest drops.
module cpu_mu0_waitreq #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-5:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  running,
    output logic [DATA_WIDTH-5:0] address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] readdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  fault
);
    localparam int ADDR_WIDTH = DATA_WIDTH - 4;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;
    localparam logic [3:0] OP_OUT = 4'd8;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH_ADDR,
        S_FETCH_DATA,
        S_EXEC_ADDR,
        S_EXEC_DATA,
        S_HALTED
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] operand;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] instr;
    logic [3:0]            opcode;
    logic [3:0]            rd_opcode;
    logic                  rd_is_load;

    assign opcode     = instr[DATA_WIDTH-1 -: 4];
    assign operand    = instr[ADDR_WIDTH-1:0];
    assign rd_opcode  = readdata[DATA_WIDTH-1 -: 4];
    assign rd_is_load = (rd_opcode == OP_LDA) || (rd_opcode == OP_ADD) || (rd_opcode == OP_SUB);
    assign pc_inc     = pc + ADDR_WIDTH'(1);
    assign writedata  = acc;

    // Control-flow target for the single-cycle EXEC_ADDR opcodes; everything else falls through.
    always_comb begin
        next_pc = pc_inc;
        case (opcode)
            OP_JMP:  next_pc = operand;
            OP_JGE:  if (!acc[DATA_WIDTH-1]) next_pc = operand;
            OP_JNE:  if (acc != '0) next_pc = operand;
            default: next_pc = pc_inc;
        endcase
    end

`ifdef MU0_ILLEGAL_TRAP_EN
    logic fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_START;
            pc        <= RESET_PC;
            acc       <= '0;
            instr     <= '0;
            running   <= 1'b0;
            address   <= RESET_PC;
            read      <= 1'b0;
            write     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef MU0_ILLEGAL_TRAP_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_START: begin
                    running <= 1'b1;
                    address <= pc;
                    read    <= 1'b1;
                    state   <= S_FETCH_ADDR;
                end
                S_FETCH_ADDR: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        state <= S_FETCH_DATA;
                    end
                end
                S_FETCH_DATA: begin
                    // Decode straight from readdata so the operand request is already on the bus in EXEC_ADDR.
                    instr   <= readdata;
                    address <= readdata[ADDR_WIDTH-1:0];
                    read    <= rd_is_load;
                    write   <= (rd_opcode == OP_STO);
                    state   <= S_EXEC_ADDR;
                end
                S_EXEC_ADDR: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            if (!waitrequest) begin
                                read  <= 1'b0;
                                state <= S_EXEC_DATA;
                            end
                        end
                        OP_STO: begin
                            if (!waitrequest) begin
                                write   <= 1'b0;
                                pc      <= pc_inc;
                                address <= pc_inc;
                                read    <= 1'b1;
                                state   <= S_FETCH_ADDR;
                            end
                        end
                        OP_JMP, OP_JGE, OP_JNE, OP_OUT: begin
                            if (opcode == OP_OUT) begin
                                out_data  <= acc;
                                out_valid <= 1'b1;
                            end
                            pc      <= next_pc;
                            address <= next_pc;
                            read    <= 1'b1;
                            state   <= S_FETCH_ADDR;
                        end
                        OP_STP: begin
                            running <= 1'b0;
                            state   <= S_HALTED;
                        end
                        default: begin
`ifdef MU0_ILLEGAL_TRAP_EN
                            fault_q <= 1'b1;
                            running <= 1'b0;
                            state   <= S_HALTED;
`else
                            pc      <= next_pc;
                            address <= next_pc;
                            read    <= 1'b1;
                            state   <= S_FETCH_ADDR;
`endif
                        end
                    endcase
                end
                S_EXEC_DATA: begin
                    case (opcode)
                        OP_ADD:  acc <= acc + readdata;
                        OP_SUB:  acc <= acc - readdata;
                        default: acc <= readdata;
                    endcase
                    pc      <= pc_inc;
                    address <= pc_inc;
                    read    <= 1'b1;
                    state   <= S_FETCH_ADDR;
                end
                S_HALTED: begin
                    read  <= 1'b0;
                    write <= 1'b0;
                end
                default: begin
                    running <= 1'b0;
                    read    <= 1'b0;
                    write   <= 1'b0;
                    state   <= S_HALTED;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mu0_waitreq.sv
// Bench for cpu_mu0_waitreq: instruction-level reference model, stalling memory slave, per-cycle bus monitor.
`timescale 1ns/1ps
module tb_cpu_mu0_waitreq;
    localparam int DW  = 16;
    localparam int AW  = 12;
    localparam int MSZ = 4096;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } bus_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          running, read, write, waitrequest, out_valid, fault;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata, readdata, out_data;

    logic          rst_b = 1'b0;
    logic          running_b, read_b, write_b, out_valid_b, fault_b;
    logic          waitrequest_b = 1'b0;
    logic [3:0]    address_b;
    logic [7:0]    writedata_b, readdata_b, out_data_b;

    always #5 clk = ~clk;

    cpu_mu0_waitreq #(.DATA_WIDTH(DW), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst(rst), .running(running), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .readdata(readdata),
        .out_valid(out_valid), .out_data(out_data), .fault(fault)
    );

    cpu_mu0_waitreq #(.DATA_WIDTH(8), .RESET_PC(4'hF)) dut_b (
        .clk(clk), .rst(rst_b), .running(running_b), .address(address_b), .read(read_b), .write(write_b),
        .waitrequest(waitrequest_b), .writedata(writedata_b), .readdata(readdata_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .fault(fault_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] img [MSZ];
    logic [DW-1:0] mem [MSZ];
    logic [DW-1:0] mm  [MSZ];
    logic [7:0]    mem8 [16];
    logic [3:0]    fa_q [$];

    bus_t          exp_q   [$];
    logic [DW-1:0] exp_out [$];
    bit            m_halt, m_fault, m_trunc;
    logic [AW-1:0] m_pc;
    int            m_cyc;

    int  stall_mode = 0;
    int  fixed_n    = 0;
    int  wr_count   = 0;
    bit  mon_en     = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Instruction-level model: replays the program and lists the bus transactions and OUT values it implies.
    task automatic model_run(input int max_instr);
        logic [AW-1:0] pc;
        logic [DW-1:0] acc, ins;
        logic [3:0]    op;
        logic [AW-1:0] s;
        int            n;
        mm = img;
        exp_q.delete();
        exp_out.delete();
        pc = '0; acc = '0; m_halt = 0; m_fault = 0; m_cyc = 0; n = 0;
        while (!m_halt && n < max_instr) begin
            ins = mm[pc];
            op  = ins[DW-1:DW-4];
            s   = ins[AW-1:0];
            exp_q.push_back({1'b0, pc, DW'(0)});
            m_cyc += 3;
            case (op)
                4'd0, 4'd2, 4'd3: begin
                    exp_q.push_back({1'b0, s, DW'(0)});
                    m_cyc += 1;
                    if (op == 4'd0)      acc = mm[s];
                    else if (op == 4'd2) acc = acc + mm[s];
                    else                 acc = acc - mm[s];
                    pc = pc + AW'(1);
                end
                4'd1: begin
                    exp_q.push_back({1'b1, s, acc});
                    mm[s] = acc;
                    pc = pc + AW'(1);
                end
                4'd4: pc = s;
                4'd5: pc = acc[DW-1] ? pc + AW'(1) : s;
                4'd6: pc = (acc != '0) ? s : pc + AW'(1);
                4'd7: m_halt = 1;
                4'd8: begin
                    exp_out.push_back(acc);
                    pc = pc + AW'(1);
                end
                default: begin
`ifdef MU0_ILLEGAL_TRAP_EN
                    m_halt  = 1;
                    m_fault = 1;
`else
                    pc = pc + AW'(1);
`endif
                end
            endcase
            n++;
        end
        m_pc    = pc;
        m_trunc = !m_halt;
    endtask

    // Memory slave: commits accepted requests, answers reads one cycle later, stalls per stall_mode.
    initial begin
        logic          s_rd, s_wr, rst_edge;
        logic [AW-1:0] s_a;
        logic [DW-1:0] s_d;
        int            pend, nstall;
        waitrequest = 1'b0;
        readdata    = '0;
        pend        = 0;
        nstall      = 0;
        forever begin
            @(negedge clk);
            s_rd = read && !waitrequest;
            s_wr = write && !waitrequest;
            s_a  = address;
            s_d  = writedata;
            @(posedge clk);
            rst_edge = rst;
            #1;
            if (!rst_edge) begin
                s_rd = 1'b0;
                s_wr = 1'b0;
            end
            if (s_wr) begin
                mem[s_a] = s_d;
                wr_count++;
            end
            readdata = s_rd ? mem[s_a] : DW'($urandom);
            if (s_rd || s_wr || !(read || write)) pend = 0;
            if (read || write) begin
                if (pend == 0)
                    nstall = (stall_mode == 2) ? $urandom_range(0, 3) : ((stall_mode == 1) ? fixed_n : 0);
                waitrequest = (pend < nstall);
                pend++;
            end else begin
                waitrequest = 1'($urandom);
            end
        end
    end

    logic [31:0] prev_bus;
    bit          prev_stall;
    int          run_cyc, stall_cyc, outs_seen;
    logic [DW-1:0] last_out;
    bus_t        e;
    logic [DW-1:0] eo;

    always @(negedge clk) begin
        if (mon_en && rst) begin
            chk("rw_exclusive", 32'(read && write), 32'(0));
            if (prev_stall) chk("bus_stable", 32'({address, read, write, writedata}), prev_bus);
            prev_stall = (read || write) && waitrequest;
            prev_bus   = 32'({address, read, write, writedata});
            if (prev_stall) stall_cyc++;
            if (running) run_cyc++;
            if ((read || write) && !waitrequest) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("acc_is_write", 32'(write), 32'(e.wr));
                    chk("acc_addr", 32'(address), 32'(e.a));
                    if (e.wr) chk("acc_wdata", 32'(writedata), 32'(e.d));
                end else if (!m_trunc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_access: got addr 0x%0h, expected no access", address);
                end
            end
            if (out_valid) begin
                outs_seen++;
                last_out = out_data;
                if (exp_out.size() != 0) begin
                    eo = exp_out.pop_front();
                    chk("out_data", 32'(out_data), 32'(eo));
                end else if (!m_trunc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_out: got 0x%0h, expected no OUT", out_data);
                end
            end
        end else begin
            prev_stall = 1'b0;
            run_cyc    = 0;
            stall_cyc  = 0;
            outs_seen  = 0;
        end
    end

    // Narrow-width instance: zero-wait slave that logs every fetched/read address.
    initial begin
        logic       rb;
        logic [3:0] ab;
        readdata_b = '0;
        forever begin
            @(negedge clk);
            rb = read_b && rst_b;
            ab = address_b;
            if (rb) fa_q.push_back(ab);
            @(posedge clk);
            #1;
            readdata_b = rb ? mem8[ab] : 8'h00;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("reset_ctrl", 32'({running, read, write, out_valid, fault}), 32'(0));
        chk("reset_out_data", 32'(out_data), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_img();
        for (int i = 0; i < MSZ; i++) img[i] = 16'h7000;
    endtask

    task automatic run_prog(input int max_instr, input int mode, input int fn, input string tag);
        bit seen, done;
        stall_mode = mode;
        fixed_n    = fn;
        mon_en     = 1'b0;
        do_reset();
        mem = img;
        model_run(max_instr);
        mon_en = 1'b1;
        #2 rst = 1'b1;
        seen = 0;
        done = 0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            #1;
            if (running) seen = 1;
            done = m_trunc ? (exp_q.size() == 0) : (seen && !running);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no completion, expected %0d pending accesses drained", tag, exp_q.size());
        end else if (!m_trunc) begin
            repeat (3) @(negedge clk);
            #1;
            chk({tag, "_cycles"}, 32'(run_cyc), 32'(m_cyc + stall_cyc));
            chk({tag, "_halted_bus"}, 32'({running, read, write}), 32'(0));
            chk({tag, "_fault"}, 32'(fault), 32'(m_fault));
            chk({tag, "_pc"}, 32'(dut.pc), 32'(m_pc));
            chk({tag, "_acc_left"}, 32'(exp_q.size()), 32'(0));
            chk({tag, "_out_left"}, 32'(exp_out.size()), 32'(0));
        end
        mon_en = 1'b0;
    endtask

    task automatic gen_random();
        logic [3:0]    op;
        logic [AW-1:0] s;
        clear_img();
        for (int i = 32; i < 48; i++) img[i] = DW'($urandom);
        for (int i = 0; i < 32; i++) begin
            op = 4'($urandom_range(0, 9));
            if (op == 4'd9) op = 4'($urandom_range(9, 15));
            if (op == 4'd4 || op == 4'd5 || op == 4'd6) s = AW'($urandom_range(0, 47));
            else                                        s = AW'($urandom_range(32, 47));
            img[i] = {op, s};
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        // LDA 5 / ADD 6 / OUT / STP, no stalls
        clear_img();
        img[0] = 16'h0005; img[1] = 16'h2006; img[2] = 16'h8000; img[3] = 16'h7000;
        img[5] = 16'h0003; img[6] = 16'h0004;
        run_prog(100, 0, 0, "t1");
        chk("t1_out_value", 32'(last_out), 32'h7);
        chk("t1_out_hold", 32'(out_data), 32'h7);
        chk("t1_out_count", 32'(outs_seen), 32'd1);
        chk("t1_total_cycles", 32'(run_cyc), 32'd14);

        // Same program, every request stalled three cycles
        run_prog(100, 1, 3, "t2");
        chk("t2_out_value", 32'(last_out), 32'h7);
        chk("t2_stall_cycles", 32'(stall_cyc), 32'd18);
        chk("t2_total_cycles", 32'(run_cyc), 32'(14 + stall_cyc));

        // JGE on negative acc falls through
        clear_img();
        img[0] = 16'h0009; img[1] = 16'h5020; img[2] = 16'h8000; img[3] = 16'h7000;
        img[9] = 16'hFFFF;
        run_prog(100, 2, 0, "t3a");
        chk("t3a_out_value", 32'(last_out), 32'hFFFF);
        chk("t3a_out_count", 32'(outs_seen), 32'd1);
        img[9] = 16'h0000;
        run_prog(100, 2, 0, "t3b");
        chk("t3b_out_count", 32'(outs_seen), 32'd0);
        chk("t3b_pc", 32'(dut.pc), 32'h20);

        // STO accepted after a two-cycle stall, then reset during the following fetch stall
        clear_img();
        img[0] = 16'h0005; img[1] = 16'h1007; img[5] = 16'h1234; img[7] = 16'h0000;
        stall_mode = 1;
        fixed_n    = 2;
        mon_en     = 1'b0;
        do_reset();
        mem = img;
        model_run(2);
        wr_count = 0;
        mon_en = 1'b1;
        #2 rst = 1'b1;
        for (int c = 0; c < 200 && wr_count == 0; c++) @(negedge clk);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (read && waitrequest) break;
        end
        chk("t4_fetch_stall_seen", 32'(read && waitrequest), 32'(1));
        #2;
        mon_en = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        chk("t4_write_count", 32'(wr_count), 32'd1);
        chk("t4_mem7", 32'(mem[7]), 32'h1234);
        chk("t4_idle_bus", 32'({running, read, write}), 32'(0));

        // Illegal opcode 0xA at address 2
        clear_img();
        img[0] = 16'h0005; img[1] = 16'h8000; img[2] = 16'hA000; img[3] = 16'h8000; img[4] = 16'h7000;
        img[5] = 16'h0042;
        run_prog(100, 2, 0, "t5");
`ifdef MU0_ILLEGAL_TRAP_EN
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_pc", 32'(dut.pc), 32'h2);
        chk("t5_out_count", 32'(outs_seen), 32'd1);
`else
        chk("t5_fault", 32'(fault), 32'd0);
        chk("t5_pc", 32'(dut.pc), 32'h4);
        chk("t5_out_count", 32'(outs_seen), 32'd2);
`endif

        // Randomized programs and stalls
        for (int r = 0; r < 10; r++) begin
            gen_random();
            run_prog(60, 2, 0, "rnd");
        end

        // Narrow core: JMP 0xF at 0xF keeps fetching 0xF
        for (int i = 0; i < 16; i++) mem8[i] = 8'h00;
        mem8[15] = 8'h4F;
        fa_q.delete();
        @(negedge clk);
        #2 rst_b = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("w8_jmp_fetches", 32'(fa_q.size() >= 3), 32'(1));
        foreach (fa_q[i]) chk("w8_jmp_addr", 32'(fa_q[i]), 32'hF);

        // LDA at 0xF: pc wraps to 0x0
        rst_b = 1'b0;
        #1;
        chk("w8_reset_ctrl", 32'({running_b, read_b, write_b}), 32'(0));
        mem8[15] = 8'h03; mem8[3] = 8'h55; mem8[0] = 8'h70;
        @(negedge clk);
        fa_q.delete();
        #2 rst_b = 1'b1;
        repeat (14) @(negedge clk);
        #1;
        chk("w8_lda_reads", 32'(fa_q.size()), 32'd3);
        if (fa_q.size() == 3) begin
            chk("w8_read0", 32'(fa_q[0]), 32'hF);
            chk("w8_read1", 32'(fa_q[1]), 32'h3);
            chk("w8_read2", 32'(fa_q[2]), 32'h0);
        end
        chk("w8_acc", 32'(writedata_b), 32'h55);
        chk("w8_running", 32'(running_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
